serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl_pkg.sv | 9 +
 rtl/serial_fa_cell.sv | 19 +
 rtl/serial_adder_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding and default width for the serial adder
package serial_adder_ctrl_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: full adder with a carry flop, cleared on each new operation
module serial_fa_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  logic carry;
  assign s  = a ^ b ^ carry;
  assign co = (a & b) | (a & carry) | (b & carry);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) carry <= 1'b0;
    else if (clr) carry <= 1'b0;
    else if (en) carry <= co;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer with start/done handshake
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] sa, sb, sr, sr_nxt;
  logic [CW-1:0] cnt;
  logic s, co, accept, last;
  assign busy   = state == ST_SHIFT;
  assign done   = state == ST_DONE;
  assign accept = state == ST_IDLE && start;
  assign last   = cnt == CW'(WIDTH - 1);
  assign sr_nxt = {s, sr[WIDTH-1:1]};
  serial_fa_cell u_fa (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (busy),
    .a    (sa[0]),
    .b    (sb[0]),
    .s    (s),
    .co   (co)
  );
  // the unused encoding 2'd3 falls through to IDLE
  always_comb begin
    nxt = ST_IDLE;
    if (state == ST_IDLE) nxt = start ? ST_SHIFT : ST_IDLE;
    else if (state == ST_SHIFT) nxt = last ? ST_DONE : ST_SHIFT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        cnt <= '0;
      end else if (busy) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        sr  <= sr_nxt;
        cnt <= cnt + CW'(1);
        if (last) begin
          sum  <= sr_nxt;
          cout <= co;
        end
      end
    end
endmodule
